// File: rtl/core_rvfi_retire_ctrl.sv
// rtl/core_rvfi_retire_ctrl.sv - RVFI retirement sequencer for a single-issue commit point
// Wait-state watchdog is built only when CORE_RVFI_RETIRE_TIMEOUT_EN is defined.
module core_rvfi_retire_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            i_load,
  input  logic            i_store,
  input  logic            i_rd_wen,
  input  logic            i_trap,
  input  logic [31:0]     i_insn,
  input  logic [XLEN-1:0] i_pc,
  input  logic            mem_rsp_valid,
  input  logic            mem_rsp_error,
  input  logic            rd_valid,
  output logic            n_valid,
  output logic            n_trap,
  output logic [31:0]     n_insn,
  output logic [XLEN-1:0] n_pc_rdata,
  output logic [XLEN-1:0] n_order,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    WAIT_WB  = 2'd2,
    RETIRE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load_f;
  logic   rd_f;
  logic   rd_seen;
  logic   accept;
  logic   trap_set;
  logic   tmo_fire;
  logic   in_wait;

  assign accept  = i_valid && i_ready;
  assign in_wait = (state == WAIT_RSP) || (state == WAIT_WB);

`ifdef CORE_RVFI_RETIRE_TIMEOUT_EN
  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);

  logic [7:0] tmo_cnt;
  logic [8:0] tmo_inc;
  logic       tmo_hit;

  // tmo_inc counts the current wait cycle, so the limit fires on wait cycle TIMEOUT
  assign tmo_inc  = {1'b0, tmo_cnt} + 9'd1;
  assign tmo_hit  = in_wait && (tmo_inc == TMO_LIMIT);
  assign tmo_fire = tmo_hit &&
                    (((state == WAIT_RSP) && !mem_rsp_valid) ||
                     ((state == WAIT_WB)  && !rd_valid));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      tmo_cnt     <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if ((state_nxt == WAIT_RSP || state_nxt == WAIT_WB) && (state_nxt != state)) begin
        tmo_cnt <= 8'd0;
      end else if (in_wait) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (tmo_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    trap_set  = 1'b0;
    case (state)
      IDLE, RETIRE: begin
        if (accept) begin
          if (i_trap) begin
            state_nxt = RETIRE;
          end else if (i_load || i_store) begin
            state_nxt = WAIT_RSP;
          end else if (i_rd_wen && !rd_valid) begin
            state_nxt = WAIT_WB;
          end else begin
            state_nxt = RETIRE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_error) begin
            state_nxt = RETIRE;
            trap_set  = 1'b1;
          end else if (load_f && rd_f && !rd_seen && !rd_valid) begin
            state_nxt = WAIT_WB;
          end else begin
            state_nxt = RETIRE;
          end
        end else if (tmo_fire) begin
          state_nxt = RETIRE;
          trap_set  = 1'b1;
        end
      end
      WAIT_WB: begin
        if (rd_valid) begin
          state_nxt = RETIRE;
        end else if (tmo_fire) begin
          state_nxt = RETIRE;
          trap_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // i_ready and n_valid are registered copies of the next state's decode
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state      <= IDLE;
      i_ready    <= 1'b1;
      n_valid    <= 1'b0;
      n_trap     <= 1'b0;
      n_insn     <= 32'd0;
      n_pc_rdata <= '0;
      n_order    <= '0;
      load_f     <= 1'b0;
      rd_f       <= 1'b0;
      rd_seen    <= 1'b0;
    end else begin
      state   <= state_nxt;
      i_ready <= (state_nxt == IDLE) || (state_nxt == RETIRE);
      n_valid <= (state_nxt == RETIRE);
      if (n_valid) begin
        n_order <= n_order + XLEN'(1);
      end
      if (accept) begin
        n_insn     <= i_insn;
        n_pc_rdata <= i_pc;
        n_trap     <= i_trap;
        load_f     <= i_load;
        rd_f       <= i_rd_wen;
        rd_seen    <= rd_valid;
      end else begin
        if (trap_set) begin
          n_trap <= 1'b1;
        end
        if (in_wait && rd_valid) begin
          rd_seen <= 1'b1;
        end
      end
    end
  end

endmodule
